// File: rtl/dram_maint_sched_if.sv
// rtl/dram_maint_sched_if.sv - AXI address gating and maintenance request/ack bundle
interface dram_maint_sched_if;
    logic aw_valid_i;
    logic aw_ready_o;
    logic aw_valid_o;
    logic aw_ready_i;
    logic ar_valid_i;
    logic ar_ready_o;
    logic ar_valid_o;
    logic ar_ready_i;
    logic b_hs_i;
    logic r_last_hs_i;
    logic ref_req_o;
    logic ref_ack_i;
    logic zq_req_o;
    logic zq_ack_i;

    modport slave (
        input  aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
        input  b_hs_i, r_last_hs_i, ref_ack_i, zq_ack_i,
        output aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o,
        output ref_req_o, zq_req_o
    );

    modport master (
        output aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
        output b_hs_i, r_last_hs_i, ref_ack_i, zq_ack_i,
        input  aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o,
        input  ref_req_o, zq_req_o
    );
endinterface

// File: rtl/dram_maint_sched.sv
// rtl/dram_maint_sched.sv - periodic refresh/ZQ scheduler gating AXI address traffic
// Optional statistics outputs enabled by DRAM_MAINT_STATS_EN.
module dram_maint_sched #(
    parameter int RefPeriod  = 7800,
    parameter int ZqPeriod   = 1000000,
    parameter int MaxTxns    = 16,
    parameter int AckTimeout = 4096
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     calib_done_i,
    dram_maint_sched_if.slave        bus,
    output logic                     busy_o,
    output logic                     err_o
`ifdef DRAM_MAINT_STATS_EN
    ,
    output logic [31:0]              ref_cnt_o,
    output logic [31:0]              zq_cnt_o,
    output logic [15:0]              drain_max_o
`endif
);
    localparam int CW = $clog2(MaxTxns + 1);
    localparam int RW = (RefPeriod > 1) ? $clog2(RefPeriod) : 1;
    localparam int ZW = (ZqPeriod > 1) ? $clog2(ZqPeriod) : 1;
    localparam int TW = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
    localparam logic [RW-1:0] REF_LOAD = RW'((RefPeriod > 0) ? RefPeriod - 1 : 0);
    localparam logic [ZW-1:0] ZQ_LOAD  = ZW'((ZqPeriod > 0) ? ZqPeriod - 1 : 0);
    localparam logic [TW-1:0] TMO_LAST = TW'((AckTimeout > 0) ? AckTimeout - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MaxTxns);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_DRAIN, S_REQ} state_t;

    state_t        r_state;
    logic          r_block, r_busy, r_err;
    logic          r_ref_req, r_zq_req, r_ref_due, r_zq_due;
    logic          r_aw_pend, r_ar_pend;
    logic [CW-1:0] r_wr_cnt, r_rd_cnt;
    logic [RW-1:0] r_ref_tmr;
    logic [ZW-1:0] r_zq_tmr;
    logic [TW-1:0] r_tmo_cnt;

    logic w_allow_aw, w_allow_ar, w_aw_valid_o, w_ar_valid_o, w_aw_hs, w_ar_hs;
    logic w_wr_under, w_rd_under, w_in_req, w_ack, w_tmo, w_ref_clr, w_zq_clr;
    logic w_tmr_run, w_ref_exp, w_zq_exp, w_ref_ovr, w_zq_ovr, w_drained;

    // A pending valid always passes so an address already presented is never withdrawn.
    assign w_allow_aw   = (~r_block & (r_wr_cnt != CNT_MAX)) | r_aw_pend;
    assign w_allow_ar   = (~r_block & (r_rd_cnt != CNT_MAX)) | r_ar_pend;
    assign w_aw_valid_o = bus.aw_valid_i & w_allow_aw;
    assign w_ar_valid_o = bus.ar_valid_i & w_allow_ar;
    assign w_aw_hs      = w_aw_valid_o & bus.aw_ready_i;
    assign w_ar_hs      = w_ar_valid_o & bus.ar_ready_i;
    assign w_wr_under   = bus.b_hs_i & ~w_aw_hs & (r_wr_cnt == '0);
    assign w_rd_under   = bus.r_last_hs_i & ~w_ar_hs & (r_rd_cnt == '0);

    assign w_in_req  = (r_state == S_REQ) & calib_done_i;
    assign w_ack     = w_in_req & ((r_ref_req & bus.ref_ack_i) | (r_zq_req & bus.zq_ack_i));
    assign w_tmo     = w_in_req & ~w_ack & (r_tmo_cnt == TMO_LAST);
    assign w_ref_clr = (w_ack | w_tmo) & r_ref_req;
    assign w_zq_clr  = (w_ack | w_tmo) & r_zq_req;
    assign w_tmr_run = (r_state != S_INIT);
    assign w_ref_exp = w_tmr_run && (RefPeriod != 0) && (r_ref_tmr == '0);
    assign w_zq_exp  = w_tmr_run && (ZqPeriod != 0) && (r_zq_tmr == '0);
    assign w_ref_ovr = w_ref_exp & r_ref_due & ~w_ref_clr;
    assign w_zq_ovr  = w_zq_exp & r_zq_due & ~w_zq_clr;
    assign w_drained = (r_wr_cnt == '0) & (r_rd_cnt == '0) & ~r_aw_pend & ~r_ar_pend;

    assign bus.aw_valid_o = w_aw_valid_o;
    assign bus.ar_valid_o = w_ar_valid_o;
    assign bus.aw_ready_o = bus.aw_ready_i & w_allow_aw;
    assign bus.ar_ready_o = bus.ar_ready_i & w_allow_ar;
    assign bus.ref_req_o  = r_ref_req;
    assign bus.zq_req_o   = r_zq_req;
    assign busy_o         = r_busy;
    assign err_o          = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_aw_pend <= 1'b0;
            r_ar_pend <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
        end else begin
            r_aw_pend <= w_aw_valid_o & ~bus.aw_ready_i;
            r_ar_pend <= w_ar_valid_o & ~bus.ar_ready_i;
            if (w_aw_hs & ~bus.b_hs_i)
                r_wr_cnt <= r_wr_cnt + 1'b1;
            else if (~w_aw_hs & bus.b_hs_i & (r_wr_cnt != '0))
                r_wr_cnt <= r_wr_cnt - 1'b1;
            if (w_ar_hs & ~bus.r_last_hs_i)
                r_rd_cnt <= r_rd_cnt + 1'b1;
            else if (~w_ar_hs & bus.r_last_hs_i & (r_rd_cnt != '0))
                r_rd_cnt <= r_rd_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_INIT;
            r_block   <= 1'b1;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_ref_req <= 1'b0;
            r_zq_req  <= 1'b0;
            r_ref_due <= 1'b0;
            r_zq_due  <= 1'b0;
            r_ref_tmr <= REF_LOAD;
            r_zq_tmr  <= ZQ_LOAD;
            r_tmo_cnt <= '0;
        end else begin
            if (w_wr_under | w_rd_under | w_tmo | w_ref_ovr | w_zq_ovr)
                r_err <= 1'b1;

            if (w_tmr_run && (RefPeriod != 0))
                r_ref_tmr <= (r_ref_tmr == '0) ? REF_LOAD : r_ref_tmr - 1'b1;
            if (w_tmr_run && (ZqPeriod != 0))
                r_zq_tmr <= (r_zq_tmr == '0) ? ZQ_LOAD : r_zq_tmr - 1'b1;

            // Expiry is written last so a new period is not lost when it lands on a clear.
            if (w_ref_clr) r_ref_due <= 1'b0;
            if (w_zq_clr)  r_zq_due  <= 1'b0;
            if (w_ref_exp) r_ref_due <= 1'b1;
            if (w_zq_exp)  r_zq_due  <= 1'b1;

            if ((r_state != S_INIT) && !calib_done_i) begin
                r_state   <= S_INIT;
                r_block   <= 1'b1;
                r_busy    <= 1'b1;
                r_ref_req <= 1'b0;
                r_zq_req  <= 1'b0;
            end else begin
                case (r_state)
                    S_INIT: begin
                        r_block <= 1'b1;
                        r_busy  <= ~calib_done_i;
                        if (calib_done_i) r_state <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (r_ref_due | r_zq_due) begin
                            r_block <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_DRAIN;
                        end else begin
                            r_block <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_DRAIN: begin
                        if (w_drained) begin
                            r_ref_req <= r_ref_due;
                            r_zq_req  <= ~r_ref_due;
                            r_tmo_cnt <= '0;
                            r_state   <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (w_ack | w_tmo) begin
                            r_ref_req <= 1'b0;
                            r_zq_req  <= 1'b0;
                            r_block   <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_INIT;
                endcase
            end
        end
    end

`ifdef DRAM_MAINT_STATS_EN
    logic [31:0] r_ref_cnt, r_zq_cnt;
    logic [15:0] r_drain_cyc, r_drain_max;
    logic [15:0] w_drain_nxt;

    assign w_drain_nxt = (r_drain_cyc == 16'hFFFF) ? r_drain_cyc : r_drain_cyc + 16'd1;
    assign ref_cnt_o   = r_ref_cnt;
    assign zq_cnt_o    = r_zq_cnt;
    assign drain_max_o = r_drain_max;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ref_cnt   <= '0;
            r_zq_cnt    <= '0;
            r_drain_cyc <= '0;
            r_drain_max <= '0;
        end else begin
            if (w_ack & r_ref_req) r_ref_cnt <= r_ref_cnt + 32'd1;
            if (w_ack & r_zq_req)  r_zq_cnt  <= r_zq_cnt + 32'd1;
            if (r_state == S_DRAIN) begin
                r_drain_cyc <= w_drain_nxt;
                if (w_drain_nxt > r_drain_max) r_drain_max <= w_drain_nxt;
            end else begin
                r_drain_cyc <= '0;
            end
        end
    end
`endif
endmodule
